// File: rtl/dsp_chain_capture_if.sv
`default_nettype none
// ============================================================================
// dsp_chain_capture_if : control, tap-product and register-read bundle. Rev 1.0
// ============================================================================
interface dsp_chain_capture_if #(
  parameter int TAPS  = 5,
  parameter int WIDTH = 18
);
  logic                    start;
  logic [TAPS*WIDTH-1:0]   product_in;
  logic                    busy;
  logic                    done;
  logic                    timed_out;
  logic                    rd_en;
  logic [3:0]              rd_addr;
  logic [31:0]             rd_data;
  logic                    rd_valid;

  modport master (
    output start, product_in, rd_en, rd_addr,
    input  busy, done, timed_out, rd_data, rd_valid
  );

  modport slave (
    input  start, product_in, rd_en, rd_addr,
    output busy, done, timed_out, rd_data, rd_valid
  );
endinterface
`default_nettype wire

// File: rtl/dsp_chain_capture.sv
`default_nettype none
// ============================================================================
// dsp_chain_capture : first non-zero product and arrival cycle per tap. Rev 1.0
// ============================================================================
module dsp_chain_capture #(
  parameter int TAPS    = 5,
  parameter int WIDTH   = 18,
  parameter int TIMEOUT = 15,
  parameter int CW      = 8
) (
  input wire                 clk,
  input wire                 reset,
  dsp_chain_capture_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [TAPS-1:0]     seen_q, seen_d;
  logic [WIDTH-1:0]    val_q [TAPS];
  logic [WIDTH-1:0]    val_d [TAPS];
  logic [CW-1:0]       arr_q [TAPS];
  logic [CW-1:0]       arr_d [TAPS];
  logic                timed_out_q, timed_out_d;
  logic                rd_valid_q;
  logic [31:0]         rd_data_q, rd_data_d;
  logic [TAPS-1:0]     hit_w;

  generate
    for (genvar t = 0; t < TAPS; t++) begin : g_tap
      assign hit_w[t] = (state_q == S_RUN) && !seen_q[t] &&
                        (bus.product_in[t*WIDTH +: WIDTH] != '0);
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    seen_d      = seen_q;
    val_d       = val_q;
    arr_d       = arr_q;
    timed_out_d = timed_out_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d     = S_RUN;
          cnt_d       = '0;
          seen_d      = '0;
          timed_out_d = 1'b0;
          for (int t = 0; t < TAPS; t++) begin
            val_d[t] = '0;
            arr_d[t] = '0;
          end
        end
      end
      S_RUN: begin
        for (int t = 0; t < TAPS; t++) begin
          if (hit_w[t]) begin
            seen_d[t] = 1'b1;
            val_d[t]  = bus.product_in[t*WIDTH +: WIDTH];
            arr_d[t]  = cnt_q;
          end
        end
        // Completion wins over timeout when the last tap lands on the final sample.
        if (&seen_d) begin
          state_d     = S_DONE;
          timed_out_d = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          state_d     = S_DONE;
          timed_out_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reads see the registered results only; a capture in the same cycle is not forwarded.
  always_comb begin
    rd_data_d = rd_data_q;
    if (bus.rd_en) begin
      rd_data_d = '0;
      for (int t = 0; t < TAPS; t++) begin
        if (bus.rd_addr[3:1] == 3'(t)) begin
          if (bus.rd_addr[0]) begin
            rd_data_d[31]     = seen_q[t];
            rd_data_d[CW-1:0] = arr_q[t];
          end else begin
            rd_data_d[WIDTH-1:0] = val_q[t];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      seen_q      <= '0;
      timed_out_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      for (int t = 0; t < TAPS; t++) begin
        val_q[t] <= '0;
        arr_q[t] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      seen_q      <= seen_d;
      timed_out_q <= timed_out_d;
      rd_valid_q  <= bus.rd_en;
      rd_data_q   <= rd_data_d;
      for (int t = 0; t < TAPS; t++) begin
        val_q[t] <= val_d[t];
        arr_q[t] <= arr_d[t];
      end
    end
  end

  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.timed_out = timed_out_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_dsp_chain_capture.sv
`default_nettype none
// ============================================================================
// tb_dsp_chain_capture : randomized runs against an arrival-schedule model. Rev 1.0
// ============================================================================
module tb_dsp_chain_capture;
  localparam int TAPS    = 5;
  localparam int WIDTH   = 18;
  localparam int TIMEOUT = 15;
  localparam int CW      = 8;
  localparam int NEVER   = 99;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dsp_chain_capture_if #(.TAPS(TAPS), .WIDTH(WIDTH)) bus ();

  dsp_chain_capture #(
    .TAPS(TAPS), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CW(CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } rd_exp_t;

  rd_exp_t     sb[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_rd = '0;

  // Model: each tap's first non-zero cycle (NEVER if none) and its value.
  // m_lim = number of samples already absorbed into the visible results.
  int               m_a [TAPS];
  logic [WIDTH-1:0] m_v [TAPS];
  int               m_lim = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [3:0] addr);
    int t;
    t = int'(addr[3:1]);
    if (t >= TAPS) return 32'h0;
    if (m_a[t] >= m_lim) return 32'h0;
    if (addr[0]) return 32'h8000_0000 | 32'(m_a[t]);
    return 32'(m_v[t]);
  endfunction

  task automatic push_read(input logic [3:0] addr, input logic [31:0] exp);
    rd_exp_t e;
    bus.rd_en   = 1'b1;
    bus.rd_addr = addr;
    e.data      = exp;
    e.due       = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic random_products();
    logic [TAPS*WIDTH-1:0] p;
    for (int t = 0; t < TAPS; t++)
      p[t*WIDTH +: WIDTH] = WIDTH'($urandom_range(1, (1 << WIDTH) - 1));
    bus.product_in = p;
  endtask

  task automatic drive_products(input int n);
    logic [TAPS*WIDTH-1:0] p;
    for (int t = 0; t < TAPS; t++) begin
      if (n < m_a[t])       p[t*WIDTH +: WIDTH] = '0;
      else if (n == m_a[t]) p[t*WIDTH +: WIDTH] = m_v[t];
      else                  p[t*WIDTH +: WIDTH] = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom);
    end
    bus.product_in = p;
  endtask

  task automatic random_schedule(input int max_a, input int never_odds);
    for (int t = 0; t < TAPS; t++) begin
      m_a[t] = ($urandom_range(0, never_odds) == 0) ? NEVER : int'($urandom_range(0, max_a));
      m_v[t] = WIDTH'($urandom_range(1, (1 << WIDTH) - 1));
    end
  endtask

  task automatic run_capture(input int abort_at);
    int  last;
    bit  all_in;
    all_in = 1'b1;
    last   = 0;
    for (int t = 0; t < TAPS; t++) begin
      if (m_a[t] > TIMEOUT) all_in = 1'b0;
      else if (m_a[t] > last) last = m_a[t];
    end
    if (!all_in) last = TIMEOUT;

    bus.start = 1'b1;
    bus.rd_en = 1'b0;
    random_products();
    tick();
    bus.start = 1'b0;
    m_lim = 0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
    check("done_after_start", 32'(bus.done), 32'd0);
    check("tout_after_start", 32'(bus.timed_out), 32'd0);

    for (int n = 0; n <= last; n++) begin
      drive_products(n);
      bus.start = ($urandom_range(0, 3) == 0);
      m_lim = n;
      bus.rd_en = 1'b0;
      if (n == abort_at) begin
        reset = 1'b1;
      end else if (n == 0) begin
        push_read({3'($urandom_range(0, TAPS - 1)), 1'b1}, 32'h0);
      end else if ($urandom_range(0, 2) == 0) begin
        logic [3:0] a;
        a = 4'($urandom);
        push_read(a, model_rd(a));
      end
      tick();
      bus.rd_en = 1'b0;
      if (n == abort_at) begin
        reset     = 1'b0;
        bus.start = 1'b0;
        m_lim     = 0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_tout", 32'(bus.timed_out), 32'd0);
        return;
      end
      if (n == last) begin
        check("end_done", 32'(bus.done), 32'd1);
        check("end_busy", 32'(bus.busy), 32'd0);
        check("end_tout", 32'(bus.timed_out), 32'(!all_in));
      end else begin
        check("run_busy", 32'(bus.busy), 32'd1);
        check("run_done", 32'(bus.done), 32'd0);
      end
    end
    bus.start = 1'b0;
    m_lim = last + 1;
  endtask

  // Scoreboard monitor: pops the expectation due at this cycle, else checks hold.
  always @(negedge clk) begin : mon
    rd_exp_t e;
    if (reset) begin
      last_rd = '0;
      check("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
      check("reset_rd_data", bus.rd_data, 32'h0);
    end else if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("rd_valid_pulse", 32'(bus.rd_valid), 32'd1);
      check("rd_data", bus.rd_data, e.data);
      last_rd = e.data;
    end else begin
      check("rd_valid_idle", 32'(bus.rd_valid), 32'd0);
      check("rd_data_hold", bus.rd_data, last_rd);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start      = 1'b0;
    bus.rd_en      = 1'b0;
    bus.rd_addr    = '0;
    bus.product_in = '0;
    for (int t = 0; t < TAPS; t++) begin
      m_a[t] = NEVER;
      m_v[t] = '0;
    end

    // Reset with random inputs
    reset = 1'b1;
    repeat (3) begin
      bus.start   = 1'($urandom);
      bus.rd_addr = 4'($urandom);
      random_products();
      tick();
    end
    reset     = 1'b0;
    bus.start = 1'b0;
    m_lim     = 0;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_tout", 32'(bus.timed_out), 32'd0);
    push_read(4'd1, 32'h0);
    tick();
    bus.rd_en = 1'b0;
    tick();

    // Full arrival at cnt 0,2,3,5,6
    m_a = '{0, 2, 3, 5, 6};
    m_v = '{18'h11F97, 18'h4, 18'h10, 18'h14, 18'h18};
    run_capture(NEVER);
    push_read(4'd0, 32'h0001_1F97);
    tick();
    push_read(4'd1, 32'h8000_0000);
    tick();
    push_read(4'd9, 32'h8000_0006);
    tick();
    push_read(4'hE, 32'h0);
    tick();
    bus.rd_en = 1'b0;
    tick();

    // Timeout: tap 4 stays zero
    random_schedule(TIMEOUT, 1000);
    m_a[4] = NEVER;
    run_capture(NEVER);
    push_read(4'd9, 32'h0);
    tick();
    push_read(4'd8, 32'h0);
    tick();
    bus.rd_en = 1'b0;

    // Restart from DONE: tap 1 arrives at cnt 1 with 0x4
    random_schedule(5, 1000);
    m_a[1] = 1;
    m_v[1] = 18'h4;
    run_capture(NEVER);
    push_read(4'd3, 32'h8000_0001);
    tick();
    push_read(4'd2, 32'h0000_0004);
    tick();
    bus.rd_en = 1'b0;

    // Reset at cnt 3
    random_schedule(10, 1000);
    m_a[4] = 10;
    run_capture(3);
    for (int a = 0; a < 16; a++) begin
      push_read(4'(a), 32'h0);
      tick();
    end
    bus.rd_en = 1'b0;
    tick();

    // Randomized runs
    repeat (25) begin
      random_schedule(TIMEOUT, 11);
      run_capture(NEVER);
      repeat ($urandom_range(0, 2)) begin
        random_products();
        tick();
      end
      repeat (4) begin
        logic [3:0] a;
        a = 4'($urandom);
        random_products();
        push_read(a, model_rd(a));
        tick();
      end
      bus.rd_en = 1'b0;
    end

    repeat (3) tick();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
